// File: rtl/branch_predictor.sv
// Fetch-stage next-PC predictor: direct-mapped BTB with saturating
// direction counters and a circular return-address stack.
module branch_predictor #(
    parameter int XLEN      = 64,
    parameter int ENTRIES   = 64,
    parameter int CNT_WIDTH = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] f_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [1:0]      upd_kind,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = XLEN - IDX - 2;
    localparam int RP  = $clog2(RAS_DEPTH);

    localparam logic [CNT_WIDTH-1:0] CNT_WEAK = CNT_WIDTH'(1) << (CNT_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [RP:0]          RAS_FULL = (RP+1)'(RAS_DEPTH);

    typedef enum logic [1:0] {
        K_BR   = 2'd0,
        K_JMP  = 2'd1,
        K_CALL = 2'd2,
        K_RET  = 2'd3
    } kind_e;

    logic                 valid   [ENTRIES];
    logic [TW-1:0]        tags    [ENTRIES];
    logic [1:0]           kinds   [ENTRIES];
    logic [XLEN-1:0]      targets [ENTRIES];
    logic [CNT_WIDTH-1:0] cnts    [ENTRIES];

    logic [XLEN-1:0] slots [RAS_DEPTH];
    logic [RP-1:0]   tp;
    logic [RP:0]     count;

    logic [IDX-1:0] f_idx;
    logic [TW-1:0]  f_tag;
    logic           f_hit;

    assign f_idx = f_pc[IDX+1:2];
    assign f_tag = f_pc[XLEN-1:IDX+2];
    assign f_hit = valid[f_idx] && (tags[f_idx] == f_tag);

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = f_pc + XLEN'(4);
        if (f_hit) begin
            unique case (kind_e'(kinds[f_idx]))
                K_BR: begin
                    if (cnts[f_idx][CNT_WIDTH-1]) begin
                        pred_taken  = 1'b1;
                        pred_target = targets[f_idx];
                    end
                end
                K_JMP, K_CALL: begin
                    pred_taken  = 1'b1;
                    pred_target = targets[f_idx];
                end
                K_RET: begin
                    pred_taken  = 1'b1;
                    pred_target = (count != '0) ? slots[tp] : targets[f_idx];
                end
            endcase
        end
    end

    logic [IDX-1:0]       u_idx;
    logic [TW-1:0]        u_tag;
    logic                 u_br_hit;
    logic                 is_br;
    logic                 alloc;
    logic                 cnt_upd;
    logic                 cnt_wr;
    logic                 tgt_wr;
    logic [CNT_WIDTH-1:0] cnt_cur;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 push;
    logic                 pop;

    assign u_idx    = upd_pc[IDX+1:2];
    assign u_tag    = upd_pc[XLEN-1:IDX+2];
    assign u_br_hit = valid[u_idx] && (tags[u_idx] == u_tag)
                      && (kinds[u_idx] == K_BR);
    assign is_br    = (upd_kind == K_BR);
    assign cnt_cur  = cnts[u_idx];

    // A not-taken branch that misses never allocates.
    assign alloc   = upd_valid && (!is_br || (upd_taken && !u_br_hit));
    assign cnt_upd = upd_valid && is_br && u_br_hit;
    assign cnt_wr  = (alloc && is_br) || cnt_upd;
    assign tgt_wr  = alloc || (cnt_upd && upd_taken);

    always_comb begin
        cnt_next = cnt_cur;
        if (alloc) begin
            cnt_next = CNT_WEAK;
        end else if (upd_taken) begin
            if (cnt_cur != CNT_MAX) cnt_next = cnt_cur + CNT_WIDTH'(1);
        end else begin
            if (cnt_cur != '0) cnt_next = cnt_cur - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                cnts[i]  <= '0;
            end
        end else begin
            if (alloc) valid[u_idx] <= 1'b1;
            if (cnt_wr) cnts[u_idx] <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (alloc) begin
                tags[u_idx]  <= u_tag;
                kinds[u_idx] <= upd_kind;
            end
            if (tgt_wr) targets[u_idx] <= upd_target;
        end
    end

    assign push = upd_valid && (upd_kind == K_CALL);
    assign pop  = upd_valid && (upd_kind == K_RET) && (count != '0);

    // Overflow keeps count saturated; the oldest slot is overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            tp    <= '0;
            count <= '0;
        end else if (push) begin
            tp    <= tp + RP'(1);
            if (count != RAS_FULL) count <= count + (RP+1)'(1);
        end else if (pop) begin
            tp    <= tp - RP'(1);
            count <= count - (RP+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) slots[tp + RP'(1)] <= upd_pc + XLEN'(4);
    end

endmodule
